seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised Mealy serial-pattern detector. It is the successor to the fixed 4-bit "1001" detector.
//  - The pattern is PAT_W bits wide and can be loaded at runtime.
//  - A mode input selects overlapping or non-overlapping matches.
//  - An input-valid qualifier gates sampling; a saturating match counter counts hits.
//  Sits on a serial bit stream; dout feeds event/interrupt logic, match_cnt feeds status regs.
// PARAMETERS
//  PAT_W    4        pattern length in bits (>=2); first-received bit compares to pattern MSB
//  CNT_W    8        match counter width
//  RST_PAT  4'b1001  pattern value loaded by reset (PAT_W bits)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  d          in   1      serial data bit
//  d_valid    in   1      d is sampled only when 1
//  load       in   1      latch `pattern` into the internal register and restart detection
//  pattern    in   PAT_W  new pattern, used only when load=1
//  overlap    in   1      1 = overlapping matches, 0 = non-overlapping
//  dout       out  1      one-cycle pulse, registered, for each match
//  match_cnt  out  CNT_W  number of matches since reset/load; saturates
//  cnt_sat    out  1      sticky flag: match_cnt reached all-ones
// BEHAVIOUR
//  Reset values (asynchronous):
//  - pat_q=RST_PAT, hist=0, fill=0, dout=0, match_cnt=0, cnt_sat=0.
//  Internal state:
//  - hist[PAT_W-1:0]: shift history.
//  - fill in 0..PAT_W: count of valid bits held in hist.
//  - Together these form the Mealy state (fill = matched-prefix length window).
//  Accept cycle (d_valid=1, load=0):
//  - nh = {hist[PAT_W-2:0], d}.
//  - match = (fill >= PAT_W-1) && (nh == pat_q).
//  - hist <= nh; fill <= min(fill+1, PAT_W).
//  - If match and overlap=0: fill <= 0, and bits used in the match are not reused.
//  - If match and overlap=1: fill stays saturated, so the match tail can start the next match.
//  Output latency:
//  - dout <= match, i.e. dout is high the cycle after the edge that sampled the final pattern bit.
//  - dout is never combinational from d.
//  Idle cycle (d_valid=0, load=0):
//  - hist, fill, counter hold; dout <= 0.
//  Load cycle (load=1):
//  - pat_q <= pattern; hist <= 0; fill <= 0; match_cnt <= 0; cnt_sat <= 0; dout <= 0.
//  - load wins over d_valid: the d sampled in that cycle is discarded.
//  - overlap may change at any time; it takes effect on the next accept cycle.
//  Counter:
//  - On match, match_cnt <= match_cnt+1 unless already all-ones (then holds).
//  - cnt_sat <= 1 when match_cnt becomes all-ones; it is cleared only by rst or load.
//  Equivalence: PAT_W=4, RST_PAT=1001, overlap=1, d_valid=1 gives dout identical to the legacy detector.
//  Reset mid-pattern: partial progress is lost; detection restarts from fill=0 against RST_PAT.
// STRUCTURE
//  Package seq_det_pkg:
//  - localparams OVL_ON=1'b1, OVL_OFF=1'b0.
//  - Default PAT_W/CNT_W values.
//  Sub-module sat_counter #(W):
//  - Inputs clk, rst, clr, inc. Outputs q, sat.
//  - Reused for match_cnt/cnt_sat.
//  Top holds pat_q, hist, fill, match logic and the dout register.
// TESTING
//  All tests use defaults unless stated; d_valid=1 unless stated.
//  1. overlap=1, d=1,0,0,1,0,0,1 -> dout pulses the cycle after bit 4 and after bit 7; match_cnt=2.
//  2. overlap=0, same stream -> single pulse after bit 4; match_cnt=1, because bits 5-7 only refill fill to 3.
//  3. d_valid pattern 1,0,1,0,1,0,1 with bits 1,x,0,x,0,x,1 -> one pulse after the last valid bit; dout=0 in every gap cycle.
//  4. After bits 1,0,0, assert load with pattern=4'b1111 (d_valid=1 that cycle), then d=1 x5, overlap=1:
//     -> pulses after the 4th and 5th ones; match_cnt=2; the load-cycle bit is ignored.
//  5. CNT_W=2, five matches of 1001 with overlap=1 -> match_cnt stays 3 after the 3rd match; cnt_sat=1; load clears both.
//  6. After bits 1,0,0, pulse rst mid-cycle:
//     - Outputs go 0 immediately, without waiting for a clock edge.
//     - Then d=1 -> no pulse; full 1,0,0,1 -> pulse.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants for the parametrised serial-pattern detector.
package seq_det_pkg;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;

    // Next history-fill level; saturates at the pattern width.
    function automatic int fill_inc(input int fill, input int pat_w);
        return (fill >= pat_w) ? pat_w : fill + 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky all-ones flag and synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            q   <= '0;
            sat <= 1'b0;
        end else if (inc && (q != MAX)) begin
            q <= q + W'(1);
            if (q == MAX - W'(1)) sat <= 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Mealy serial-pattern detector: runtime-loadable pattern, overlap mode,
// valid-qualified sampling, registered match pulse and saturating hit count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1001)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             d_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int              FW        = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]   FILL_FULL = FW'(PAT_W);
    localparam logic [FW-1:0]   FILL_THR  = FW'(PAT_W - 1);

    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] nh;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_nxt;
    logic             accept;
    logic             match;

    // load takes priority, so the bit presented alongside it is dropped
    assign accept = d_valid & ~load;
    assign nh     = {hist[PAT_W-2:0], d};
    assign match  = accept && (fill >= FILL_THR) && (nh == pat_q);

    // Non-overlap restarts the window so matched bits cannot be reused;
    // overlap keeps fill saturated so the tail can seed the next match.
    always_comb begin
        fill_nxt = FW'(fill_inc(int'(fill), PAT_W));
        if (match && (overlap == OVL_OFF)) fill_nxt = '0;
        else if (fill == FILL_FULL)        fill_nxt = FILL_FULL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= RST_PAT;
            hist  <= '0;
            fill  <= '0;
            dout  <= 1'b0;
        end else if (load) begin
            pat_q <= pattern;
            hist  <= '0;
            fill  <= '0;
            dout  <= 1'b0;
        end else begin
            dout <= match;
            if (accept) begin
                hist <= nh;
                fill <= fill_nxt;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .inc (match),
        .q   (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default instance plus a CNT_W=2 instance for saturation.
module tb_seq_detector_param;

    logic       clk;
    logic       rst;
    logic       d;
    logic       d_valid;
    logic       load;
    logic [3:0] pattern;
    logic       overlap;
    logic       dout;
    logic [7:0] match_cnt;
    logic       cnt_sat;
    logic       dout2;
    logic [1:0] mc2;
    logic       sat2;

    int total = 0;
    int bad   = 0;

    logic s1 [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic e1 [7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic e2 [7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic v3 [7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic b3 [7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic e4 [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] m5 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic       x5 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    seq_detector_param dut (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .load(load),
        .pattern(pattern), .overlap(overlap),
        .dout(dout), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_detector_param #(.PAT_W(4), .CNT_W(2), .RST_PAT(4'b1001)) dut2 (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .load(load),
        .pattern(pattern), .overlap(overlap),
        .dout(dout2), .match_cnt(mc2), .cnt_sat(sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic dv, input logic b);
        d_valid = dv;
        d       = b;
        load    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] p, input logic dv, input logic b);
        load    = 1'b1;
        pattern = p;
        d_valid = dv;
        d       = b;
        @(posedge clk);
        #1;
        load    = 1'b0;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        #1;
        chk("rst_async_dout", 32'(dout), 32'd0);
        chk("rst_async_cnt", 32'(match_cnt), 32'd0);
        chk("rst_async_sat", 32'(cnt_sat), 32'd0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; d = 1'b0; d_valid = 1'b0; load = 1'b0;
        pattern = 4'b1001; overlap = 1'b1;
        #12;
        chk("reset_dout", 32'(dout), 32'd0);
        chk("reset_cnt", 32'(match_cnt), 32'd0);
        chk("reset_sat", 32'(cnt_sat), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: overlapping 1001001 -> two hits
        do_load(4'b1001, 1'b0, 1'b0);
        overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, s1[i]);
            chk($sformatf("t1_dout%0d", i), 32'(dout), 32'(e1[i]));
        end
        chk("t1_cnt", 32'(match_cnt), 32'd2);

        // 2: non-overlapping, same stream -> one hit
        do_load(4'b1001, 1'b0, 1'b0);
        chk("t2_cnt_clr", 32'(match_cnt), 32'd0);
        overlap = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, s1[i]);
            chk($sformatf("t2_dout%0d", i), 32'(dout), 32'(e2[i]));
        end
        chk("t2_cnt", 32'(match_cnt), 32'd1);

        // 3: gaps in d_valid carry junk bits that must be ignored
        do_load(4'b1001, 1'b0, 1'b0);
        overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(v3[i], b3[i]);
            chk($sformatf("t3_dout%0d", i), 32'(dout), (i == 6) ? 32'd1 : 32'd0);
        end
        chk("t3_cnt", 32'(match_cnt), 32'd1);

        // 4: reload to 1111 mid-stream; the load-cycle bit is discarded
        do_load(4'b1001, 1'b0, 1'b0);
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
        do_load(4'b1111, 1'b1, 1'b1);
        chk("t4_load_dout", 32'(dout), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            chk($sformatf("t4_dout%0d", i), 32'(dout), 32'(e4[i]));
        end
        chk("t4_cnt", 32'(match_cnt), 32'd2);

        // 5: 2-bit counter saturates at 3 over five overlapping hits
        do_load(4'b1001, 1'b0, 1'b0);
        overlap = 1'b1;
        step(1'b1, 1'b1);
        for (int m = 0; m < 5; m++) begin
            step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b1);
            chk($sformatf("t5_dout2_%0d", m), 32'(dout2), 32'd1);
            chk($sformatf("t5_cnt2_%0d", m), 32'(mc2), 32'(m5[m]));
            chk($sformatf("t5_sat2_%0d", m), 32'(sat2), 32'(x5[m]));
        end
        chk("t5_cnt_wide", 32'(match_cnt), 32'd5);
        chk("t5_sat_wide", 32'(cnt_sat), 32'd0);
        do_load(4'b1001, 1'b0, 1'b0);
        chk("t5_clr_cnt2", 32'(mc2), 32'd0);
        chk("t5_clr_sat2", 32'(sat2), 32'd0);

        // 6: async reset mid-cycle clears outputs and partial progress, restores RST_PAT
        do_load(4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        chk("t6_pre_dout", 32'(dout), 32'd1);
        chk("t6_pre_cnt", 32'(match_cnt), 32'd1);
        rst_pulse();
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b0);
        rst_pulse();
        step(1'b1, 1'b1);
        chk("t6_no_pulse", 32'(dout), 32'd0);
        step(1'b1, 1'b0);
        chk("t6_b2", 32'(dout), 32'd0);
        step(1'b1, 1'b0);
        chk("t6_b3", 32'(dout), 32'd0);
        step(1'b1, 1'b1);
        chk("t6_pulse", 32'(dout), 32'd1);
        chk("t6_cnt", 32'(match_cnt), 32'd1);
        step(1'b0, 1'b1);
        chk("t6_idle_dout", 32'(dout), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
